// File: rtl/mem_port_responder_pkg.sv
// Shared types and constants for the two-port memory responder.
package mem_port_responder_pkg;

  typedef logic [31:0] rv32i_word;

  // Latency counter width; covers LATENCY values 1..15.
  localparam int unsigned CNT_W = 4;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_A,
    BUSY_B,
    RESP
  } resp_state_t;

endpackage

// File: rtl/mem_port_responder_array.sv
// Word array: combinational read, synchronous byte-lane write.
// Contents are deliberately never reset.
module mem_word_array
  import mem_port_responder_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              i_clk,
  input  logic [ADDR_W-1:0] i_index,
  input  logic [3:0]        i_we,
  input  rv32i_word         i_wdata,
  output rv32i_word         o_rdata
);

  rv32i_word r_mem [2**ADDR_W];

  assign o_rdata = r_mem[i_index];

  // Update only the byte lanes whose enable is set.
  always_ff @(posedge i_clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (i_we[i]) r_mem[i_index][8*i +: 8] <= i_wdata[8*i +: 8];
    end
  end

endmodule

// File: rtl/mem_port_responder.sv
// Responder for the instruction-fetch (A) and data (B) memory ports.
// One access in flight, fixed-priority grant, LATENCY cycles grant->resp,
// followed by one dead cycle so a still-held request is not re-served.
module mem_port_responder
  import mem_port_responder_pkg::*;
#(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned B_PRIORITY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        read_a,
  input  logic [31:0] address_a,
  output logic        resp_a,
  output logic [31:0] rdata_a,
  input  logic        read_b,
  input  logic        write,
  input  logic [3:0]  wmask,
  input  logic [31:0] address_b,
  input  logic [31:0] wdata,
  output logic        resp_b,
  output logic [31:0] rdata_b
);

  localparam cnt_t LAT_INIT = cnt_t'(LATENCY - 1);
  localparam logic LAT_ONE  = (LATENCY == 1);

  resp_state_t       r_state;
  resp_state_t       w_next;
  cnt_t              r_cnt;
  logic [ADDR_W-1:0] r_idx;
  rv32i_word         r_wdata;
  logic [3:0]        r_wmask;
  logic              r_op_write;
  rv32i_word         r_rdata_a;
  rv32i_word         r_rdata_b;

  logic [ADDR_W-1:0] w_idx_a;
  logic [ADDR_W-1:0] w_idx_b;
  logic [ADDR_W-1:0] w_idx;
  logic              w_req_a;
  logic              w_req_b;
  logic              w_grant_a;
  logic              w_grant_b;
  logic              w_last;
  logic              w_resp_a;
  logic              w_resp_b;
  logic              w_load_a;
  logic              w_load_b;
  logic [3:0]        w_we;
  rv32i_word         w_arr_rdata;
  logic              w_unused_addr;

  assign w_idx_a = address_a[ADDR_W+1:2];
  assign w_idx_b = address_b[ADDR_W+1:2];
  assign w_unused_addr = ^{address_a[31:ADDR_W+2], address_a[1:0],
                           address_b[31:ADDR_W+2], address_b[1:0]};

  assign w_req_a   = read_a;
  assign w_req_b   = read_b | write;
  assign w_grant_b = w_req_b && ((B_PRIORITY != 0) || !w_req_a);
  assign w_grant_a = w_req_a && !w_grant_b;
  assign w_last    = (r_cnt == '0);

  mem_word_array #(.ADDR_W(ADDR_W)) u_array (
    .i_clk   (clk),
    .i_index (w_idx),
    .i_we    (w_we),
    .i_wdata (r_wdata),
    .o_rdata (w_arr_rdata)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state: grant from IDLE, count down in BUSY, one dead RESP cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant_b)      w_next = BUSY_B;
        else if (w_grant_a) w_next = BUSY_A;
      end
      BUSY_A, BUSY_B: if (w_last) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs and strobes. The rdata registers load on the edge that enters
  // the resp cycle, so read data is valid alongside resp. No write can land
  // between that load and the resp cycle, so the word equals what the array
  // holds during resp (and is the pre-write word for a port B write).
  always_comb begin
    w_idx    = r_idx;
    w_resp_a = 1'b0;
    w_resp_b = 1'b0;
    w_load_a = 1'b0;
    w_load_b = 1'b0;
    w_we     = '0;
    case (r_state)
      IDLE: begin
        w_idx    = w_grant_b ? w_idx_b : w_idx_a;
        w_load_a = w_grant_a && LAT_ONE;
        w_load_b = w_grant_b && LAT_ONE;
      end
      BUSY_A: begin
        w_resp_a = w_last;
        w_load_a = (r_cnt == cnt_t'(1));
      end
      BUSY_B: begin
        w_resp_b = w_last;
        w_load_b = (r_cnt == cnt_t'(1));
        w_we     = (w_last && r_op_write && rst_n) ? r_wmask : '0;
      end
      default: ;
    endcase
  end

  // Grant-time capture, latency countdown and read-data registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_idx      <= '0;
      r_wdata    <= '0;
      r_wmask    <= '0;
      r_op_write <= 1'b0;
      r_rdata_a  <= '0;
      r_rdata_b  <= '0;
    end else begin
      if (r_state == IDLE && (w_grant_a || w_grant_b)) begin
        r_cnt      <= LAT_INIT;
        r_idx      <= w_idx;
        r_wdata    <= wdata;
        r_wmask    <= wmask;
        r_op_write <= w_grant_b && write;
      end else if ((r_state == BUSY_A || r_state == BUSY_B) && !w_last) begin
        r_cnt <= r_cnt - cnt_t'(1);
      end
      if (w_load_a) r_rdata_a <= w_arr_rdata;
      if (w_load_b) r_rdata_b <= w_arr_rdata;
    end
  end

  assign resp_a  = w_resp_a;
  assign resp_b  = w_resp_b;
  assign rdata_a = r_rdata_a;
  assign rdata_b = r_rdata_b;

endmodule

// File: tb/tb_mem_port_responder.sv
// Scoreboard bench for mem_port_responder with default parameters.
module tb_mem_port_responder;

  localparam int LAT = 2;

  typedef struct {
    logic [31:0] data;
    bit          chk_data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        read_a = 1'b0;
  logic [31:0] address_a = '0;
  logic        resp_a;
  logic [31:0] rdata_a;
  logic        read_b = 1'b0;
  logic        write = 1'b0;
  logic [3:0]  wmask = '0;
  logic [31:0] address_b = '0;
  logic [31:0] wdata = '0;
  logic        resp_b;
  logic [31:0] rdata_b;

  exp_t qa[$];
  exp_t qb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   nresp_b = 0;

  mem_port_responder #(.ADDR_W(10), .LATENCY(LAT), .B_PRIORITY(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .read_a(read_a), .address_a(address_a), .resp_a(resp_a), .rdata_a(rdata_a),
    .read_b(read_b), .write(write), .wmask(wmask), .address_b(address_b),
    .wdata(wdata), .resp_b(resp_b), .rdata_b(rdata_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a response.
  always @(negedge clk) begin
    exp_t e;
    if (resp_a || resp_b) chk("resp_exclusive", {31'b0, resp_a & resp_b}, 32'd0);
    if (resp_a) begin
      if (qa.size() == 0) chk("resp_a_unexpected", 32'd1, 32'd0);
      else begin
        e = qa.pop_front();
        chk("resp_a_cycle", cyc, e.cyc);
        if (e.chk_data) chk("rdata_a", rdata_a, e.data);
      end
    end
    if (resp_b) begin
      nresp_b++;
      if (qb.size() == 0) chk("resp_b_unexpected", 32'd1, 32'd0);
      else begin
        e = qb.pop_front();
        chk("resp_b_cycle", cyc, e.cyc);
        if (e.chk_data) chk("rdata_b", rdata_b, e.data);
      end
    end
  end

  task automatic wait_resp(input bit port_b);
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (port_b ? resp_b : resp_a) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      chk(port_b ? "resp_b_timeout" : "resp_a_timeout", 32'd0, 32'd1);
      if (port_b) qb.delete(); else qa.delete();
    end
  endtask

  // Two edges give the DUT time to pass RESP and return to IDLE.
  task automatic do_a(input logic [31:0] addr, input logic [31:0] exp_d);
    @(posedge clk); @(posedge clk); #1;
    address_a = addr; read_a = 1'b1;
    qa.push_back('{exp_d, 1'b1, cyc + LAT});
    wait_resp(1'b0);
    read_a = 1'b0;
  endtask

  task automatic do_b(input bit rd, input bit wr, input logic [3:0] m,
                      input logic [31:0] addr, input logic [31:0] d,
                      input logic [31:0] exp_d, input bit chk_d);
    @(posedge clk); @(posedge clk); #1;
    read_b = rd; write = wr; wmask = m; address_b = addr; wdata = d;
    qb.push_back('{exp_d, chk_d, cyc + LAT});
    wait_resp(1'b1);
    read_b = 1'b0; write = 1'b0;
  endtask

  initial begin
    int snap;
    // Power-up reset.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp_a", {31'b0, resp_a}, 32'd0);
    chk("rst_resp_b", {31'b0, resp_b}, 32'd0);
    chk("rst_rdata_a", rdata_a, 32'd0);
    chk("rst_rdata_b", rdata_b, 32'd0);
    rst_n = 1'b1;

    // Array contents survive reset; rdata registers do not.
    do_b(1'b0, 1'b1, 4'hF, 32'h40, 32'hCAFEF00D, 32'h0, 1'b0);
    do_b(1'b1, 1'b0, 4'h0, 32'h40, 32'h0, 32'hCAFEF00D, 1'b1);
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst2_rdata_b", rdata_b, 32'd0);
    rst_n = 1'b1;
    do_a(32'h40, 32'hCAFEF00D);

    // Full write then fetch-port read.
    do_b(1'b0, 1'b1, 4'hF, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0);
    do_a(32'h100, 32'hDEADBEEF);

    // Byte mask: lanes 0 and 2 updated; write returns the pre-write word.
    do_b(1'b0, 1'b1, 4'hF, 32'h8, 32'h11223344, 32'h0, 1'b0);
    do_b(1'b0, 1'b1, 4'b0101, 32'h8, 32'hAABBCCDD, 32'h11223344, 1'b1);
    do_b(1'b1, 1'b0, 4'h0, 32'h8, 32'h0, 32'h11BB33DD, 1'b1);

    // Simultaneous reads: B granted first; A then waits through B's resp
    // cycle, the RESP dead cycle, one IDLE grant cycle and its own latency.
    @(posedge clk); @(posedge clk); #1;
    address_a = 32'h100; read_a = 1'b1;
    address_b = 32'h8;   read_b = 1'b1;
    qb.push_back('{32'h11BB33DD, 1'b1, cyc + 2});
    qa.push_back('{32'hDEADBEEF, 1'b1, cyc + 6});
    wait_resp(1'b1);
    read_b = 1'b0;
    wait_resp(1'b0);
    read_a = 1'b0;

    // read_b+write together is a write; wmask=0 responds but changes nothing.
    do_b(1'b1, 1'b1, 4'h0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b1);
    do_a(32'h100, 32'hDEADBEEF);

    // Aliasing: upper and low address bits ignored.
    do_b(1'b0, 1'b1, 4'hF, 32'h4, 32'h5, 32'h0, 1'b0);
    do_a(32'h1004, 32'h5);
    do_b(1'b1, 1'b0, 4'h0, 32'h1006, 32'h0, 32'h5, 1'b1);

    // Reset in the cycle before resp aborts the write.
    do_b(1'b0, 1'b1, 4'hF, 32'h20, 32'hA5A5A5A5, 32'h0, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    write = 1'b1; wmask = 4'hF; address_b = 32'h20; wdata = 32'h12345678;
    snap = nresp_b;
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 write = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_no_resp_b", nresp_b - snap, 32'd0);
    chk("abort_rdata_b", rdata_b, 32'd0);
    rst_n = 1'b1;
    do_b(1'b1, 1'b0, 4'h0, 32'h20, 32'h0, 32'hA5A5A5A5, 1'b1);

    repeat (4) @(posedge clk);
    chk("qa_drained", qa.size(), 32'd0);
    chk("qb_drained", qb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
